// File: rtl/event_pending_issue.sv
// Sticky event collector with lowest-index-first issue onto a valid/ready stream.
// Events are captured into a pending vector; each issued position retires its bit.
module event_pending_issue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned POS_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] ev,
    input  logic [WIDTH-1:0] mask,
    input  logic             ovf_clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [POS_W-1:0] out_pos,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overflow
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] clr;
    logic             load;
    logic             found;

    always_comb begin
        cap     = ev & ~mask;
        load    = !valid_q || out_ready;
        clr     = '0;
        found   = 1'b0;
        valid_d = valid_q;
        pos_d   = pos_q;

        if (load) begin
            valid_d = 1'b0;
            // Ascending scan with a found flag: first set bit wins, later ones ignored.
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (pending_q[i] && !found) begin
                    found   = 1'b1;
                    valid_d = 1'b1;
                    pos_d   = POS_W'(i);
                    clr[i]  = 1'b1;
                end
            end
        end

        // A capture on the bit being retired keeps it pending and is not an overflow.
        pending_d  = (pending_q & ~clr) | cap;
        overflow_d = (ovf_clr ? '0 : overflow_q) | (cap & pending_q & ~clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q  <= '0;
            overflow_q <= '0;
            valid_q    <= 1'b0;
            pos_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            pos_q      <= pos_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pos   = pos_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_event_pending_issue.sv
// Bench for event_pending_issue: directed vector table, mid-stream reset, and a
// randomized run against a set-arithmetic reference model.
module tb_event_pending_issue;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ev, mask;
    logic       ovf_clr, out_ready;
    logic       out_valid;
    logic [2:0] out_pos;
    logic [7:0] pending, overflow;

    int errors = 0;
    int checks = 0;

    bit [7:0] m_pend, m_ovf;
    bit       m_valid;
    bit [2:0] m_pos;

    typedef struct {
        logic [7:0] ev;
        logic [7:0] mask;
        logic       oc;
        logic       rdy;
        logic       v;
        logic [2:0] pos;
        logic [7:0] pend;
        logic [7:0] ovf;
    } vec_t;

    vec_t tbl[32];

    event_pending_issue #(.WIDTH(8), .POS_W(3)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ev       (ev),
        .mask     (mask),
        .ovf_clr  (ovf_clr),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_pos  (out_pos),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [2:0] p,
                             input logic [7:0] pe, input logic [7:0] o);
        cmp({tag, " out_valid"}, {7'b0, out_valid}, {7'b0, v});
        cmp({tag, " out_pos"},   {5'b0, out_pos},   {5'b0, p});
        cmp({tag, " pending"},   pending,           pe);
        cmp({tag, " overflow"},  overflow,          o);
    endtask

    // Reference: pending is a set of sources; the lowest member is isolated as p & -p.
    task automatic model_edge();
        bit [7:0] c, lsb, retire;
        c      = ev & ~mask;
        retire = 8'h00;
        if (!m_valid || out_ready) begin
            if (m_pend != 0) begin
                lsb     = m_pend & (~m_pend + 8'd1);
                retire  = lsb;
                m_pos   = 3'($clog2(lsb));
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_ovf  = (ovf_clr ? 8'h00 : m_ovf) | (c & m_pend & ~retire);
        m_pend = (m_pend & ~retire) | c;
    endtask

    task automatic model_reset();
        m_pend  = 8'h00;
        m_ovf   = 8'h00;
        m_valid = 1'b0;
        m_pos   = 3'd0;
    endtask

    task automatic step(input logic [7:0] e, input logic [7:0] m, input logic oc, input logic r);
        ev        = e;
        mask      = m;
        ovf_clr   = oc;
        out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        //            ev     mask   oc    rdy   v     pos   pend   ovf
        tbl[0]  = '{8'hA4, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'hA4, 8'h00};
        tbl[1]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'hA0, 8'h00};
        tbl[2]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h80, 8'h00};
        tbl[3]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h00, 8'h00};
        tbl[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 8'h00};
        tbl[5]  = '{8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 8'h12, 8'h00};
        tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 8'h00};
        tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 8'h00};
        tbl[8]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 8'h00};
        tbl[9]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 8'h00};
        tbl[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 8'h00};
        tbl[11] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h11, 8'h00};
        tbl[12] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h10, 8'h00};
        tbl[13] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h00, 8'h00};
        tbl[14] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 8'h00};
        tbl[15] = '{8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h04, 8'h00};
        tbl[16] = '{8'h04, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 8'h00};
        tbl[17] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00, 8'h00};
        tbl[18] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h00};
        tbl[19] = '{8'h0A, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h0A, 8'h00};
        tbl[20] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h08, 8'h00};
        tbl[21] = '{8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h08, 8'h08};
        tbl[22] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'h08, 8'h00};
        tbl[23] = '{8'h08, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'h08, 8'h08};
        tbl[24] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 8'h08};
        tbl[25] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00};
        tbl[26] = '{8'hFF, 8'h0F, 1'b0, 1'b1, 1'b0, 3'd3, 8'hF0, 8'h00};
        tbl[27] = '{8'h0F, 8'h0F, 1'b0, 1'b1, 1'b1, 3'd4, 8'hE0, 8'h00};
        tbl[28] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'hC0, 8'h00};
        tbl[29] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd6, 8'h80, 8'h00};
        tbl[30] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h00, 8'h00};
        tbl[31] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 8'h00};

        resetn    = 1'b0;
        ev        = 8'h00;
        mask      = 8'h00;
        ovf_clr   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check_all("reset", 1'b0, 3'd0, 8'h00, 8'h00);
        #10 resetn = 1'b1;

        for (int i = 0; i < 32; i++) begin
            step(tbl[i].ev, tbl[i].mask, tbl[i].oc, tbl[i].rdy);
            check_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].pos, tbl[i].pend, tbl[i].ovf);
        end

        // Mid-stream asynchronous reset while a position is being presented.
        step(8'hFF, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        check_all("pre_rst", 1'b1, 3'd0, 8'hFE, 8'h00);
        resetn = 1'b0;
        #1;
        check_all("mid_rst", 1'b0, 3'd0, 8'h00, 8'h00);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 8'h00, 1'b0, 1'b1);
            check_all($sformatf("post_rst%0d", i), 1'b0, 3'd0, 8'h00, 8'h00);
        end

        for (int i = 0; i < 600; i++) begin
            logic [7:0] e, m;
            logic       oc, r;
            e  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            m  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            oc = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 2) != 0);
            step(e, m, oc, r);
            check_all($sformatf("rand%0d", i), m_valid, m_pos, m_pend, m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/event_pending_issue.md
# event_pending_issue

Sticky event collector and issue stage for an 8-source lowest-index-first encoder path. It captures single-cycle event pulses into a pending vector and repeatedly selects the lowest-numbered pending source: bit 0 has highest priority, bit 7 has lowest. Each selected source is presented as a 3-bit position on a valid/ready output, and its pending bit is retired at that moment. The block sits between raw event sources and the downstream consumer of encoded positions, turning a combinational "lowest set bit" lookup into a lossless, back-pressurable stream.

## Interface
- `WIDTH`, 8, number of event sources; fixed at 8 for this revision.
- `POS_W`, 3, width of `out_pos`; must equal log2(`WIDTH`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `ev`  in  8  event pulses, sampled every cycle; bit i set = source i fired.
- `mask`  in  8  bit i set = events on source i are ignored (not captured, no overflow).
- `ovf_clr`  in  1  synchronous clear of the `overflow` vector.
- `out_ready`  in  1  consumer accepts `out_pos` this cycle.
- `out_valid`  out  1  `out_pos` holds an issued position.
- `out_pos`  out  3  index of the issued source.
- `pending`  out  8  captured, not-yet-issued sources (registered).
- `overflow`  out  8  sticky flag; bit i set = an event on source i was merged into an already-pending bit.

## Operation
- Reset (`resetn` low, asynchronous): `pending`=0, `overflow`=0, `out_valid`=0, `out_pos`=0. Reset asserted mid-stream discards all pending and in-flight positions, with no partial issue.
- Capture: `cap` = `ev` & ~`mask`. Mask applies only at capture; bits already pending are unaffected by `mask`.
- Load condition: `load` = !`out_valid` | `out_ready`.
- Issue, on each rising edge with `load` true:
  - If `pending` != 0: `out_pos` := index of lowest set bit of `pending`, `out_valid` := 1, and that bit is the cleared bit `clr`.
  - Otherwise `out_valid` := 0, `out_pos` holds its value, and `clr` = 0.
- Pending update: `pending` := (`pending` & ~`clr`) | `cap`.
  - A capture on the bit being issued in the same cycle wins: the bit stays pending and will be issued again later.
  - That case is not an overflow.
- Overflow: bit i sets when `cap[i]` & `pending[i]` & ~`clr[i]`.
  - `ovf_clr` zeroes the whole vector.
  - A new overflow in the same cycle as `ovf_clr` wins: that bit reads 1 afterwards.
- The issue decision uses registered `pending` only; events captured this cycle are never issued in the same cycle.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_pos` and `out_valid` hold.
  - `pending` may still gain bits during this hold.
  - A newly arrived lower index does not pre-empt the held position.

## Timing
- Event to `pending`: 1 cycle. Event sampled at edge E0 appears in `pending` after E0.
- Event to `out_valid`: 2 cycles with an idle output. Issued at edge E1; the bit clears from `pending` at the same edge.
- Throughput: one position per cycle while `out_ready`=1 and `pending` != 0.
- `out_valid` drops the cycle after the last accepted position if nothing is pending.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-stream:
  - Stimulus: `ev`=0xFF, then `resetn` low for 1 cycle while `out_valid`=1.
  - Response: immediately `out_valid`=0, `pending`=0x00, `overflow`=0x00, `out_pos`=0. No positions emitted after release until new events arrive.
- Ordering:
  - Stimulus: one-cycle `ev`=0xA4, `out_ready`=1, `mask`=0.
  - Response: `out_pos` = 2, 5, 7 on three consecutive cycles, starting 2 cycles after the pulse. `pending` steps 0xA4→0xA0→0x80→0x00, then `out_valid`=0.
- Backpressure:
  - Stimulus: `ev`=0x12 pulse, `out_ready`=0 for 5 cycles, then 1.
  - Response: `out_pos`=1 with `out_valid`=1 held for all 5 cycles and `pending`=0x10. Then `out_pos`=4 on the next cycle, then `out_valid`=0.
  - Variant: add an `ev`=0x01 pulse during the hold. `out_pos`=1 still holds; the post-hold order is 0 then 4.
- Overflow:
  - Stimulus: `out_ready`=0, `ev`=0x0A pulse, then `ev`=0x08 pulse two cycles later.
  - Response: `overflow`=0x08 and `pending` bit 3 stays set.
  - Stimulus: `ovf_clr` pulse. Response: `overflow`=0x00.
  - Stimulus: `ovf_clr` together with a fresh `ev`=0x08 while bit 3 is pending. Response: `overflow`=0x08.
- Mask:
  - Stimulus: `mask`=0x0F, `ev`=0xFF pulse.
  - Response: `pending`=0xF0 and outputs 4, 5, 6, 7. `overflow` unchanged even if bits 0–3 fire again.
- Same-bit collision:
  - Stimulus: `ev`=0x04 on the exact edge where position 2 is issued.
  - Response: `pending` bit 2 remains set and position 2 is issued a second time on the next load. `overflow` stays 0x00.
